// File: rtl/delay_pkg.sv
// Shared constants and sizing helper for the parametrised delay line.
package delay_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  // ceil(log2(n)), but never below 1 so select/count ports always exist
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One data+valid register of the delay line: async clear, sync flush, enabled load.
module delay_stage
  import delay_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Flush wins over enable; without either the stage holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (flush) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/param_delay_line.sv
// WIDTH-bit, DEPTH-stage stallable delay line with valid tracking, tap read and occupancy.
module param_delay_line
  import delay_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int TW    = clog2_min1(DEPTH),
  localparam int CW    = clog2_min1(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] tap_q,
  output logic             tap_valid,
  output logic [CW-1:0]    fill
);

  // Index 0 is the gated input, index i+1 is the output of stage i
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]            vld_pipe;

  // Bubbles enter as zero so an undriven d never lands in a stage
  assign dat_pipe[0] = d_valid ? d : '0;
  assign vld_pipe[0] = d_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .flush   (flush),
      .d       (dat_pipe[i]),
      .d_valid (vld_pipe[i]),
      .q       (dat_pipe[i+1]),
      .q_valid (vld_pipe[i+1])
    );
  end

  assign q       = dat_pipe[DEPTH];
  assign q_valid = vld_pipe[DEPTH];

  // Occupancy tracks valids in minus valids out; a full line with input stays full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
    end else if (flush) begin
      fill <= '0;
    end else if (en) begin
      fill <= fill + CW'(vld_pipe[0]) - CW'(vld_pipe[DEPTH]);
    end
  end

  // Tap read; selects beyond the last stage read as zero/invalid
  always_comb begin
    tap_q     = '0;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TW'(i)) begin
        tap_q     = dat_pipe[i+1];
        tap_valid = vld_pipe[i+1];
      end
    end
  end

endmodule

// File: tb/tb_param_delay_line.sv
// Randomised + directed bench: queue-based line model and in-order output scoreboard.
module tb_param_delay_line;

  localparam int W = 4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n, en, flush, d_valid;
  logic [W-1:0] d;
  logic [1:0]   tap_sel, tap_sel3;
  logic [W-1:0] q, tap_q, q3, tap_q3;
  logic         q_valid, tap_valid, q_valid3, tap_valid3;
  logic [2:0]   fill;
  logic [1:0]   fill3;

  int checks = 0;
  int errors = 0;

  param_delay_line #(.WIDTH(W), .DEPTH(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q), .q_valid(q_valid), .tap_sel(tap_sel), .tap_q(tap_q),
    .tap_valid(tap_valid), .fill(fill)
  );

  param_delay_line #(.WIDTH(W), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q3), .q_valid(q_valid3), .tap_sel(tap_sel3), .tap_q(tap_q3),
    .tap_valid(tap_valid3), .fill(fill3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } ent_t;

  ent_t         line[$];   // line[0] = newest stage, line[N-1] = output stage
  logic [W-1:0] sb[$];     // words still owed on q, oldest first
  logic         adv = 1'b0;

  function automatic int mdl_fill();
    int n = 0;
    foreach (line[i]) n += int'(line[i].v);
    return n;
  endfunction

  task automatic mdl_clear();
    line.delete();
    for (int i = 0; i < N; i++) line.push_back('0);
    sb.delete();
  endtask

  initial mdl_clear();

  // Model follows the same edges the DUT sees; inputs are stable at the edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_clear();
      adv = 1'b0;
    end else begin
      adv = en && !flush;
      if (flush) begin
        mdl_clear();
      end else if (en) begin
        ent_t e;
        e.v = d_valid;
        e.d = d_valid ? d : '0;
        void'(line.pop_back());
        line.push_front(e);
        if (d_valid) sb.push_back(d);
      end
    end
  end

  // Monitor: mid-cycle compare of state and in-order scoreboard of emitted words
  always @(negedge clk) begin
    if (rst_n) begin
      chk("q_valid", 32'(q_valid), 32'(line[N-1].v));
      chk("fill", 32'(fill), 32'(mdl_fill()));
      chk("tap_q", 32'(tap_q), 32'(line[tap_sel].d));
      chk("tap_valid", 32'(tap_valid), 32'(line[tap_sel].v));
      if (!q_valid) chk("q_bubble_zero", 32'(q), 32'h0);
      if (adv && q_valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(q), 32'hDEAD);
        end else begin
          logic [W-1:0] exp_w;
          exp_w = sb.pop_front();
          chk("q_order", 32'(q), 32'(exp_w));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 time unit after the posedge so they are stable at the next one
  task automatic step(input logic e, input logic f, input logic v, input logic [W-1:0] dd);
    en = e; flush = f; d_valid = v; d = dd;
    @(posedge clk); #1;
  endtask

  initial begin
    int peak;
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; d_valid = 1'b1; d = 4'hF;
    tap_sel = '0; tap_sel3 = '0;

    // Reset holds everything clear even with valid input and enable active
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 0);
    chk("rst_qv", 32'(q_valid), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_fill3", 32'(fill3), 0);
    en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency and fill ramp
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 1, W'(i));
      chk("ramp_fill", 32'(fill), 32'(i));
    end
    chk("lat_q", 32'(q), 1);
    chk("lat_qv", 32'(q_valid), 1);
    for (int i = 5; i <= 7; i++) begin
      step(1, 0, 1, W'(i));
      chk("stream_q", 32'(q), 32'(i - 3));
      chk("full_fill", 32'(fill), 4);
    end

    // Asynchronous reset mid-cycle clears outputs before the next edge
    #2 rst_n = 1'b0;
    #1;
    chk("async_q", 32'(q), 0);
    chk("async_qv", 32'(q_valid), 0);
    chk("async_fill", 32'(fill), 0);
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Stall: contents, tap and fill freeze while disabled
    step(1, 0, 1, 4'hA);
    tap_sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 4'h3);
      chk("stall_tap", 32'(tap_q), 32'hA);
      chk("stall_fill", 32'(fill), 1);
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("stall_qv_early", 32'(q_valid), 0);
    step(1, 0, 0, 0);
    chk("stall_q", 32'(q), 32'hA);
    chk("stall_qv", 32'(q_valid), 1);

    // Bubbles: invalid input is zeroed and tracked as invalid
    step(0, 1, 0, 0);
    chk("flush_fill", 32'(fill), 0);
    peak = 0;
    step(1, 0, 1, 4'h5); if (int'(fill) > peak) peak = int'(fill);
    step(1, 0, 0, 4'h7); if (int'(fill) > peak) peak = int'(fill);
    step(1, 0, 1, 4'h9); if (int'(fill) > peak) peak = int'(fill);
    step(1, 0, 0, 0);    if (int'(fill) > peak) peak = int'(fill);
    chk("bub_q0", 32'({q_valid, q}), 32'h15);
    step(1, 0, 0, 0);
    chk("bub_q1", 32'({q_valid, q}), 32'h00);
    step(1, 0, 0, 0);
    chk("bub_q2", 32'({q_valid, q}), 32'h19);
    chk("bub_peak", 32'(peak), 2);

    // Flush beats enable and the word on the flush edge is dropped
    for (int i = 0; i < 4; i++) step(1, 0, 1, W'($urandom));
    chk("pre_flush_fill", 32'(fill), 4);
    step(1, 1, 1, 4'h3);
    chk("fl_fill", 32'(fill), 0);
    chk("fl_qv", 32'(q_valid), 0);
    chk("fl_q", 32'(q), 0);
    tap_sel = 2'd0;
    #1 chk("fl_tap0", 32'({tap_valid, tap_q}), 0);

    // Tap reads after feeding 1,2,3 (both DEPTH=4 and DEPTH=3 instances)
    step(1, 0, 1, 1);
    step(1, 0, 1, 2);
    step(1, 0, 1, 3);
    en = 1'b0; d_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      logic [W-1:0] ev;
      ev = (s < 3) ? W'(3 - s) : '0;
      tap_sel = 2'(s); tap_sel3 = 2'(s);
      #1;
      chk("tap4_q", 32'(tap_q), 32'(ev));
      chk("tap4_v", 32'(tap_valid), 32'(s < 3));
      chk("tap3_q", 32'(tap_q3), 32'(ev));
      chk("tap3_v", 32'(tap_valid3), 32'(s < 3));
    end
    chk("d3_q", 32'({q_valid3, q3}), 32'h11);
    @(posedge clk); #1;

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      tap_sel  = 2'($urandom);
      tap_sel3 = 2'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 2) != 0, W'($urandom));
    end
    for (int i = 0; i < N + 1; i++) step(1, 0, 0, 0);
    chk("drain_sb", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
